// File: rtl/gray_decode_stage.sv
// Sequential Gray-to-binary decoder: one bit per cycle MSB first, ready/valid on both sides.
// Optional unit-distance checker enabled by defining GRAY_STEP_CHECK_EN.
module gray_decode_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             step_err,
    output logic [7:0]       err_cnt
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic [IW-1:0]    idx_q;
    logic             acc_q;
    logic             bit_d;
    logic             accept_s;
    logic             last_bit_s;

    // Handshake qualification and the next decoded bit (acc_q carries bin[i+1]).
    always_comb begin
        accept_s   = in_valid && (state_q == IDLE);
        last_bit_s = (state_q == DECODE) && (idx_q == '0);
        bit_d      = acc_q ^ gray_q[idx_q];
    end

    // Main FSM: capture, bit-serial decode, hold until downstream accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gray_q  <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        gray_q  <= in_gray;
                        bin_q   <= '0;
                        idx_q   <= IW'(WIDTH - 1);
                        acc_q   <= 1'b0;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    bin_q[idx_q] <= bit_d;
                    acc_q        <= bit_d;
                    if (idx_q == '0) begin
                        state_q <= HOLD;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_bin   = bin_q;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic             pend_err_q;
    logic             step_err_q;
    logic [7:0]       err_cnt_q;
    logic             step_bad_s;

    function automatic logic [4:0] popcount(input logic [WIDTH-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // A word is flagged when it differs from its predecessor in anything but one bit.
    always_comb begin
        step_bad_s = have_prev_q && (popcount(in_gray ^ prev_q) != 5'd1);
    end

    // History, pending flag, and the error presented alongside the output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            pend_err_q  <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (accept_s) begin
                prev_q      <= in_gray;
                have_prev_q <= 1'b1;
                pend_err_q  <= step_bad_s;
            end
            if (last_bit_s) begin
                step_err_q <= pend_err_q;
                if (pend_err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if ((state_q == HOLD) && out_ready) begin
                step_err_q <= 1'b0;
            end
        end
    end

    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;
`else
    assign step_err = 1'b0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_gray_decode_stage.sv
// Directed self-checking bench for gray_decode_stage (WIDTH=8); expectations follow GRAY_STEP_CHECK_EN.
module tb_gray_decode_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_gray;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_bin;
    logic       step_err;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef GRAY_STEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    gray_decode_stage #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hands one word in and waits (bounded) for out_valid; returns observations only.
    task automatic run_word(input logic [7:0] g, output int lat, output logic [7:0] bin,
                            output logic err, output logic rdy_bad);
        int n;
        lat     = -1;
        bin     = 8'hxx;
        err     = 1'bx;
        rdy_bad = 1'b0;
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b1;
        in_gray  = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_gray  = 8'h5A;
        for (int c = 1; c <= 40; c++) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                bin = out_bin;
                err = step_err;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== 8'h00 ||
            step_err !== 1'b0 || err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_bin=%h step_err=%b err_cnt=%0d, expected 1 0 00 0 0",
                     in_ready, out_valid, out_bin, step_err, err_cnt);
        end
    endtask

    task automatic test_decode();
        logic [7:0] gv [5] = '{8'hC0, 8'hFF, 8'h00, 8'h55, 8'h80};
        logic [7:0] bv [5] = '{8'h80, 8'hAA, 8'h00, 8'h66, 8'hFF};
        int lat;
        logic [7:0] bin;
        logic err, rb;
        for (int i = 0; i < 5; i++) begin
            run_word(gv[i], lat, bin, err, rb);
            checks++;
            if (lat !== 8 || bin !== bv[i] || rb !== 1'b0) begin
                failures++;
                $display("FAIL decode_%h: lat=%0d bin=%h ready_leak=%b, expected lat=8 bin=%h ready_leak=0",
                         gv[i], lat, bin, rb, bv[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] bin;
        logic err, rb;
        run_word(8'hFF, lat, bin, err, rb);
        checks++;
        if (lat !== 8 || bin !== 8'hAA) begin
            failures++;
            $display("FAIL bp_first: lat=%0d bin=%h, expected lat=8 bin=aa", lat, bin);
        end
        in_valid = 1'b1;
        in_gray  = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_bin !== 8'hAA || in_ready !== 1'b0 || step_err !== err) begin
                failures++;
                $display("FAIL bp_stall%0d: out_valid=%b out_bin=%h in_ready=%b step_err=%b, expected 1 aa 0 %b",
                         c, out_valid, out_bin, in_ready, step_err, err);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored_input: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_step_sequence();
        logic [7:0] gv [3] = '{8'h01, 8'h03, 8'h00};
        logic [7:0] bv [3] = '{8'h01, 8'h02, 8'h00};
        logic       ev [3];
        int lat;
        logic [7:0] bin;
        logic err, rb;
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        ev[2] = CHK;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_word(gv[i], lat, bin, err, rb);
            checks++;
            if (lat !== 8 || bin !== bv[i] || err !== ev[i]) begin
                failures++;
                $display("FAIL step_seq%0d: lat=%0d bin=%h step_err=%b, expected lat=8 bin=%h step_err=%b",
                         i, lat, bin, err, bv[i], ev[i]);
            end
            consume();
        end
        checks++;
        if (err_cnt !== (CHK ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL step_seq_cnt: err_cnt=%0d, expected %0d", err_cnt, CHK ? 1 : 0);
        end
    endtask

    task automatic test_repeat();
        int lat;
        logic [7:0] bin;
        logic err0, err1, rb;
        do_reset();
        run_word(8'h03, lat, bin, err0, rb);
        consume();
        run_word(8'h03, lat, bin, err1, rb);
        checks++;
        if (err0 !== 1'b0 || err1 !== CHK || bin !== 8'h02) begin
            failures++;
            $display("FAIL repeat: step_err=%b,%b bin=%h, expected 0,%b bin=02", err0, err1, bin, CHK);
        end
        consume();
        checks++;
        if (err_cnt !== (CHK ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL repeat_cnt: err_cnt=%0d, expected %0d", err_cnt, CHK ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_decode();
        int lat;
        logic [7:0] bin;
        logic err, rb, seen;
        do_reset();
        run_word(8'h00, lat, bin, err, rb);
        consume();
        run_word(8'h00, lat, bin, err, rb);
        consume();
        in_valid = 1'b1;
        in_gray  = 8'h05;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_bin !== 8'h00 || err_cnt !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b out_bin=%h err_cnt=%0d in_ready=%b, expected 0 00 0 1",
                     out_valid, out_bin, err_cnt, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abandon: out_valid seen=%b, expected 0", seen);
        end
        run_word(8'hC0, lat, bin, err, rb);
        checks++;
        if (lat !== 8 || bin !== 8'h80 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_next: lat=%0d bin=%h step_err=%b, expected lat=8 bin=80 step_err=0",
                     lat, bin, err);
        end
        consume();
    endtask

    task automatic test_saturation();
        int lat;
        int bad;
        logic [7:0] bin;
        logic [7:0] cnt255;
        logic err, rb;
        do_reset();
        bad    = 0;
        cnt255 = 8'h00;
        for (int i = 1; i <= 300; i++) begin
            run_word(8'h00, lat, bin, err, rb);
            if (lat != 8 || bin != 8'h00) bad++;
            consume();
            if (i == 255) cnt255 = err_cnt;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL sat_decode: %0d bad words, expected 0", bad);
        end
        checks++;
        if (cnt255 !== (CHK ? 8'd254 : 8'd0)) begin
            failures++;
            $display("FAIL sat_pre: err_cnt=%0d, expected %0d", cnt255, CHK ? 254 : 0);
        end
        checks++;
        if (err_cnt !== (CHK ? 8'd255 : 8'd0)) begin
            failures++;
            $display("FAIL sat_final: err_cnt=%0d, expected %0d", err_cnt, CHK ? 255 : 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_step_sequence();
        test_repeat();
        test_reset_mid_decode();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_decode_stage.md
GRAY_DECODE_STAGE -- requirements
Module: gray_decode_stage

Interface
REQ-001 Parameter: WIDTH, 8, code/data width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream Gray word present on in_gray.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_gray  input  WIDTH  Gray-coded word (out[i] = b[i]^b[i+1], MSB passed through).
REQ-007 Port: out_valid  output  1  decoded binary word available.
REQ-008 Port: out_ready  input  1  downstream accepts the word this cycle.
REQ-009 Port: out_bin  output  WIDTH  decoded binary word.
REQ-010 Port: step_err  output  1  current output violated the unit-distance rule (see Configuration).
REQ-011 Port: err_cnt  output  8  saturating count of step errors since reset.

Function
REQ-012 FSM states: IDLE, DECODE, HOLD; no other reachable states.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-014 IDLE: on in_valid&in_ready, capture in_gray, clear the bit index to WIDTH-1, and go to DECODE.
REQ-015 DECODE: decode one bit per cycle, MSB first: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i].
REQ-016 DECODE lasts exactly WIDTH cycles; after resolving bit 0, go to HOLD.
REQ-017 Latency: input handshake at edge k gives out_valid=1 after edge k+WIDTH.
REQ-018 HOLD: out_bin and step_err stay stable while out_ready=0, with no limit on the stall length.
REQ-019 HOLD with out_ready=1 completes the transfer and returns to IDLE. The next accept is at the earliest one cycle later; minimum period is WIDTH+2 cycles per word.
REQ-020 in_gray and in_valid SHALL be ignored outside IDLE; upstream must hold the word until in_ready.
REQ-021 out_bin SHALL show the partially decoded register during DECODE; it is valid only while out_valid=1.

Reset
REQ-022 rst_n=0 at a rising edge: state=IDLE, in_ready=1 from the following cycle, out_valid=0, out_bin=0, step_err=0, err_cnt=0, history cleared.
REQ-023 Reset in DECODE or HOLD SHALL abandon the word; it is never output.
REQ-024 The first word accepted after reset has no predecessor and SHALL NOT flag step_err.

Configuration
REQ-025 Macro GRAY_STEP_CHECK_EN enables the unit-distance checker.
REQ-026 With the macro defined, the block stores the previous accepted Gray word. On each accept it computes the popcount of (in_gray XOR previous word); a count not equal to 1 sets step_err for that output word.
REQ-027 With the macro defined, err_cnt increments by 1 when an erroring word enters HOLD and saturates at 255.
REQ-028 Without the macro, step_err and err_cnt are tied to 0, no history register exists, and decode behaviour and timing are unchanged.

Verification
REQ-029 Basic decode, WIDTH=8: in_gray 8'hC0 -> out_bin 8'h80, out_valid exactly 8 cycles after accept; in_gray 8'hFF -> 8'hAA; in_gray 8'h00 -> 8'h00.
REQ-030 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_bin stays constant and in_ready stays 0; out_ready=1 -> return to IDLE, in_ready=1 next cycle.
REQ-031 Step check (macro on): sequence 8'h01, 8'h03, 8'h00 -> step_err 0, 0, 1; err_cnt ends at 1. Repeating 8'h03 twice also flags step_err (distance 0).
REQ-032 Macro off: same sequence -> step_err always 0, err_cnt 0, out_bin 8'h01, 8'h02, 8'h00.
REQ-033 Reset mid-DECODE (cycle 4 of 8) -> no out_valid, out_bin=0, err_cnt=0; the next word decodes correctly with step_err=0.
REQ-034 Saturation (macro on): 300 consecutive 8'h00 words -> err_cnt holds at 255.
